// File: rtl/pad_stream_ingress.sv
// ---------------------------------------------------------------------------
// pad_stream_ingress
//   Pad-side ingress stage. Registers the pad stream inputs, buffers beats in
//   a small first-word-fall-through FIFO and drives a registered pad ready
//   derived from the next-cycle occupancy. Free entries are kept in reserve
//   so that beats already in flight when ready drops can still be stored.
//   The block also counts completed frames and flags overflow.
//
//   Optional feature macro: PAD_SYNC_EN
//     defined   : two-flop input stage for asynchronous pad sources. This adds
//                 one cycle of latency and reserves one extra free entry.
//     undefined : single input register stage.
//
// Ports
//   wb_clk_i     in   clock
//   wb_rst_i     in   asynchronous reset, active-high
//   pad_valid_i  in   producer valid
//   pad_data_i   in   producer data [DATA_W]
//   pad_last_i   in   producer end-of-frame
//   pad_ready_o  out  registered ready to producer
//   m_valid_o    out  downstream valid (FIFO not empty)
//   m_data_o     out  downstream data [DATA_W]
//   m_last_o     out  downstream end-of-frame
//   m_ready_i    in   downstream ready
//   level_o      out  FIFO occupancy [log2(DEPTH)+1]
//   overflow_o   out  sticky: a beat arrived while the FIFO was full
//   frame_cnt_o  out  frames accepted into the FIFO, 16-bit wrapping
// ---------------------------------------------------------------------------
module pad_stream_ingress #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int SKID   = 2
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      pad_valid_i,
   input  logic [DATA_W-1:0]         pad_data_i,
   input  logic                      pad_last_i,
   output logic                      pad_ready_o,
   output logic                      m_valid_o,
   output logic [DATA_W-1:0]         m_data_o,
   output logic                      m_last_o,
   input  logic                      m_ready_i,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      overflow_o,
   output logic [15:0]               frame_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef PAD_SYNC_EN
   localparam int SKID_EFF = SKID + 1;
`else
   localparam int SKID_EFF = SKID;
`endif
   // Ready is held high only while more than SKID_EFF entries stay free.
   localparam int READY_LIM = DEPTH - SKID_EFF;

   logic              r_vld_q;
   logic [DATA_W-1:0] r_data_q;
   logic              r_last_q;
   logic              w_in_vld;
   logic [DATA_W-1:0] w_in_data;
   logic              w_in_last;

   logic [DATA_W:0]   r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_count_next;
   logic [DATA_W:0]   w_rd_word;
   logic              w_full;
   logic              w_rd;
   logic              w_wr_ok;
   logic              r_ready;
   logic              r_overflow;
   logic [15:0]       r_frame_cnt;

   // ---------------- input stage ----------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_vld_q  <= 1'b0;
         r_data_q <= '0;
         r_last_q <= 1'b0;
      end else begin
         r_vld_q  <= pad_valid_i;
         r_data_q <= pad_data_i;
         r_last_q <= pad_last_i;
      end
   end

`ifdef PAD_SYNC_EN
   logic              r_vld_q2;
   logic [DATA_W-1:0] r_data_q2;
   logic              r_last_q2;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_vld_q2  <= 1'b0;
         r_data_q2 <= '0;
         r_last_q2 <= 1'b0;
      end else begin
         r_vld_q2  <= r_vld_q;
         r_data_q2 <= r_data_q;
         r_last_q2 <= r_last_q;
      end
   end

   assign w_in_vld  = r_vld_q2;
   assign w_in_data = r_data_q2;
   assign w_in_last = r_last_q2;
`else
   assign w_in_vld  = r_vld_q;
   assign w_in_data = r_data_q;
   assign w_in_last = r_last_q;
`endif

   // ---------------- FIFO control ----------------
   assign w_rd_word = r_mem[r_rd_ptr];
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_rd      = m_valid_o & m_ready_i;
   // A full FIFO still accepts a beat when a read frees a slot the same cycle.
   assign w_wr_ok   = w_in_vld & (~w_full | w_rd);

   always_comb begin
      w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= {w_in_last, w_in_data};
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ready     <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_count <= w_count_next;
         r_ready <= (w_count_next < CW'(READY_LIM));
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_in_last) begin
               r_frame_cnt <= r_frame_cnt + 16'd1;
            end
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_in_vld && !w_wr_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------- outputs ----------------
   assign pad_ready_o = r_ready;
   assign m_valid_o   = (r_count != '0);
   assign m_data_o    = w_rd_word[DATA_W-1:0];
   assign m_last_o    = w_rd_word[DATA_W];
   assign level_o     = r_count;
   assign overflow_o  = r_overflow;
   assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_pad_stream_ingress.sv
// ---------------------------------------------------------------------------
// tb_pad_stream_ingress
//   Self-checking bench for pad_stream_ingress (DATA_W=8, DEPTH=8, SKID=2).
//   A cycle-by-cycle vector table covers reset, passthrough and back-pressure
//   for the single-register input stage. Hand-written sequences cover reset
//   mid-cycle, latency, ready threshold, overflow, full with simultaneous
//   read/write, and frame counter wrap. Where the timing depends on the
//   input stage, PAD_SYNC_EN selects the expected values.
// ---------------------------------------------------------------------------
module tb_pad_stream_ingress;

   localparam int DEPTH = 8;
   localparam int SKID  = 2;
`ifdef PAD_SYNC_EN
   localparam int LAT      = 2;
   localparam int SKID_EFF = SKID + 1;
`else
   localparam int LAT      = 1;
   localparam int SKID_EFF = SKID;
`endif

   logic        clk;
   logic        rst;
   logic        pv;
   logic [7:0]  pd;
   logic        pl;
   logic        pr;
   logic        mv;
   logic [7:0]  md;
   logic        ml;
   logic        mr;
   logic [3:0]  lvl;
   logic        ov;
   logic [15:0] fc;

   int checks = 0;
   int errors = 0;

   pad_stream_ingress #(
      .DATA_W (8),
      .DEPTH  (DEPTH),
      .SKID   (SKID)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .pad_valid_i (pv),
      .pad_data_i  (pd),
      .pad_last_i  (pl),
      .pad_ready_o (pr),
      .m_valid_o   (mv),
      .m_data_o    (md),
      .m_last_o    (ml),
      .m_ready_i   (mr),
      .level_o     (lvl),
      .overflow_o  (ov),
      .frame_cnt_o (fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, pv;
      logic [7:0] d;
      logic       l, mr;
      logic       e_pr, e_mv;
      logic [7:0] e_d;
      logic       e_l;
      logic [3:0] e_lvl;
      logic       e_ov;
      logic [15:0] e_fc;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic l,
                               input logic m, input logic epr, input logic emv, input logic [7:0] ed,
                               input logic el, input logic [3:0] elv, input logic eov,
                               input logic [15:0] efc);
      vec_t t;
      t.rst = r; t.pv = v; t.d = d; t.l = l; t.mr = m;
      t.e_pr = epr; t.e_mv = emv; t.e_d = ed; t.e_l = el; t.e_lvl = elv; t.e_ov = eov; t.e_fc = efc;
      return t;
   endfunction

   // Assert reset in the middle of a cycle, check outputs clear at once,
   // release on the falling edge and check ready rises on the next edge.
   task automatic reset_dut();
      pv = 1'b0; pl = 1'b0; pd = '0; mr = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("reset outputs", {pr, mv, md, ml, lvl, ov, fc}, '0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk("release ready", {28'd0, pr, lvl}, {28'd0, 1'b1, 4'd0});
   endtask

   vec_t tbl[18];

   initial begin
      int n;
      int fall_lvl;
      int max_lvl;
      logic prev_pr;
      logic found;
      int ready_low;
      logic [7:0] exp_d;

      rst = 1'b1; pv = 1'b0; pd = '0; pl = 1'b0; mr = 1'b0;

      //            rst pv d      l  mr  | pr mv d      l  lvl ov fc
      tbl[0]  = mk(1, 0, 8'h00, 0, 0,    0, 0, 8'h00, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 8'h00, 0, 1,    1, 0, 8'h00, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 8'h11, 0, 1,    1, 0, 8'h00, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 8'h22, 0, 1,    1, 1, 8'h11, 0, 1, 0, 0);
      tbl[4]  = mk(0, 1, 8'h33, 1, 1,    1, 1, 8'h22, 0, 1, 0, 0);
      tbl[5]  = mk(0, 0, 8'h00, 0, 1,    1, 1, 8'h33, 1, 1, 0, 1);
      tbl[6]  = mk(0, 0, 8'h00, 0, 1,    1, 0, 8'h00, 0, 0, 0, 1);
      tbl[7]  = mk(0, 1, 8'hA0, 0, 0,    1, 0, 8'h00, 0, 0, 0, 1);
      tbl[8]  = mk(0, 1, 8'hA1, 0, 0,    1, 1, 8'hA0, 0, 1, 0, 1);
      tbl[9]  = mk(0, 1, 8'hA2, 0, 0,    1, 1, 8'hA0, 0, 2, 0, 1);
      tbl[10] = mk(0, 1, 8'hA3, 0, 0,    1, 1, 8'hA0, 0, 3, 0, 1);
      tbl[11] = mk(0, 1, 8'hA4, 0, 0,    1, 1, 8'hA0, 0, 4, 0, 1);
      tbl[12] = mk(0, 1, 8'hA5, 0, 0,    1, 1, 8'hA0, 0, 5, 0, 1);
      tbl[13] = mk(0, 1, 8'hA6, 0, 0,    0, 1, 8'hA0, 0, 6, 0, 1);
      tbl[14] = mk(0, 0, 8'h00, 0, 0,    0, 1, 8'hA0, 0, 7, 0, 1);
      tbl[15] = mk(0, 0, 8'h00, 0, 1,    0, 1, 8'hA1, 0, 6, 0, 1);
      tbl[16] = mk(0, 0, 8'h00, 0, 1,    1, 1, 8'hA2, 0, 5, 0, 1);
      tbl[17] = mk(0, 0, 8'h00, 0, 0,    1, 1, 8'hA2, 0, 5, 0, 1);

`ifndef PAD_SYNC_EN
      // Table expectations assume the single-register input stage.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; pv = tbl[i].pv; pd = tbl[i].d; pl = tbl[i].l; mr = tbl[i].mr;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d ready", i), {31'd0, pr}, {31'd0, tbl[i].e_pr});
         chk($sformatf("row%0d valid", i), {31'd0, mv}, {31'd0, tbl[i].e_mv});
         chk($sformatf("row%0d data", i), {23'd0, ml, md}, {23'd0, tbl[i].e_l, tbl[i].e_d});
         chk($sformatf("row%0d level", i), {28'd0, lvl}, {28'd0, tbl[i].e_lvl});
         chk($sformatf("row%0d ovf", i), {31'd0, ov}, {31'd0, tbl[i].e_ov});
         chk($sformatf("row%0d frames", i), {16'd0, fc}, {16'd0, tbl[i].e_fc});
      end
`endif

      // ---- latency: pad beat to m_valid_o ----
      reset_dut();
      mr = 1'b1;
      @(negedge clk); pv = 1'b1; pd = 8'h5A; pl = 1'b1;
      @(posedge clk); n = 1;
      @(negedge clk); pv = 1'b0; pl = 1'b0; pd = '0;
      found = 1'b0;
      while (!found && n < 10) begin
         @(posedge clk); n++;
         #1;
         if (mv) begin
            found = 1'b1;
            chk("latency data", {23'd0, ml, md}, {23'd0, 1'b1, 8'h5A});
         end
      end
      chk("latency edges", n, LAT + 1);
      chk("latency frames", {16'd0, fc}, 32'd1);

      // ---- ready threshold with a well-behaved producer ----
      reset_dut();
      fall_lvl = -1; max_lvl = 0; prev_pr = pr;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); pv = pr; pd = 8'(c); pl = 1'b0;
         @(posedge clk);
         #1;
         if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
         if (prev_pr && !pr && fall_lvl < 0) fall_lvl = int'(lvl);
         prev_pr = pr;
      end
      pv = 1'b0;
      chk("ready fall level", fall_lvl, DEPTH - SKID_EFF);
      chk("bp max level ok", {31'd0, (max_lvl <= DEPTH)}, 32'd1);
      chk("bp no overflow", {31'd0, ov}, 32'd0);

      // ---- overflow: 9 forced beats into an 8-entry FIFO ----
      reset_dut();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); pv = 1'b1; pd = 8'h50 + 8'(i); pl = (i == 8);
      end
      @(negedge clk); pv = 1'b0; pl = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("ovf level", {28'd0, lvl}, 32'd8);
      chk("ovf flag", {31'd0, ov}, 32'd1);
      chk("ovf frames", {16'd0, fc}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); mr = 1'b1;
         exp_d = 8'h50 + 8'(i);
         chk($sformatf("ovf drain%0d", i), {23'd0, mv, md}, {23'd0, 1'b1, exp_d});
         @(posedge clk);
      end
      @(negedge clk);
      chk("ovf drained empty", {30'd0, mv, ov}, {30'd0, 1'b0, 1'b1});
      mr = 1'b0;

      // ---- full FIFO with write and read in the same cycle ----
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); pv = 1'b1; pd = 8'h60 + 8'(i); pl = 1'b0;
      end
      @(negedge clk); pv = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("full level", {28'd0, lvl}, 32'd8);
      @(negedge clk); pv = 1'b1; pd = 8'hEE;
      @(posedge clk);
      @(negedge clk); pv = 1'b0; pd = '0;
      for (int k = 0; k < LAT - 1; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      mr = 1'b1;
      @(posedge clk);
      #1;
      chk("full+rw level", {28'd0, lvl}, 32'd8);
      chk("full+rw no ovf", {31'd0, ov}, 32'd0);
      @(negedge clk); mr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); mr = 1'b1;
         exp_d = (i == 7) ? 8'hEE : 8'h61 + 8'(i);
         chk($sformatf("full drain%0d", i), {23'd0, mv, md}, {23'd0, 1'b1, exp_d});
         @(posedge clk);
      end
      @(negedge clk); mr = 1'b0;
      chk("full drained empty", {31'd0, mv}, 32'd0);

      // ---- frame counter wrap: 0x10001 single-beat frames ----
      reset_dut();
      mr = 1'b1; ready_low = 0;
      for (int i = 0; i < 65537; i++) begin
         @(negedge clk);
         if (!pr) ready_low++;
         pv = 1'b1; pd = 8'(i); pl = 1'b1;
      end
      @(negedge clk); pv = 1'b0; pl = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("wrap ready held", ready_low, 0);
      chk("wrap frames", {16'd0, fc}, 32'h0001);
      chk("wrap level", {28'd0, lvl}, 32'd0);
      chk("wrap no ovf", {31'd0, ov}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
